// File: rtl/menshen_deparse_pkg.sv
// Shared deparse definitions: action word field positions, size encodings,
// FSM state encoding and the size-to-bytes helper. The parser side uses the same package.
package menshen_deparse_pkg;

  // Action word layout
  localparam int ACT_EN_BIT   = 0;
  localparam int ACT_SEQ_LSB  = 1;
  localparam int ACT_SEQ_MSB  = 3;
  localparam int ACT_SIZE_LSB = 4;
  localparam int ACT_SIZE_MSB = 5;
  localparam int ACT_OFF_LSB  = 6;
  localparam int ACT_OFF_MSB  = 12;

  // Container size encodings
  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_2B   = 2'b01;
  localparam logic [1:0] SIZE_4B   = 2'b10;
  localparam logic [1:0] SIZE_6B   = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  typedef struct packed {
    logic       en;
    logic [1:0] size;
    logic [6:0] off;
  } act_dec_t;

  function automatic int size_bytes(input logic [1:0] s);
    case (s)
      SIZE_2B: return 2;
      SIZE_4B: return 4;
      SIZE_6B: return 6;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sub_deparser_if.sv
// Handshake bundle for sub_deparser: header load, write-action stream, rebuilt header.
interface sub_deparser_if #(
  parameter int PKTS_HDR_LEN    = 1024,
  parameter int DEPARSE_ACT_LEN = 16,
  parameter int VAL_IN_LEN      = 48
);
  logic                       hdr_in_valid;
  logic [PKTS_HDR_LEN-1:0]    hdr_in;
  logic                       hdr_in_ready;
  logic                       act_valid;
  logic [DEPARSE_ACT_LEN-1:0] act;
  logic [VAL_IN_LEN-1:0]      act_val;
  logic                       act_last;
  logic                       act_ready;
  logic                       hdr_out_valid;
  logic [PKTS_HDR_LEN-1:0]    hdr_out;
  logic                       hdr_out_ready;

  // Upstream/downstream side driving the deparser
  modport master (
    output hdr_in_valid, hdr_in, act_valid, act, act_val, act_last, hdr_out_ready,
    input  hdr_in_ready, act_ready, hdr_out_valid, hdr_out
  );

  // Deparser side
  modport slave (
    input  hdr_in_valid, hdr_in, act_valid, act, act_val, act_last, hdr_out_ready,
    output hdr_in_ready, act_ready, hdr_out_valid, hdr_out
  );
endinterface

// File: rtl/deparse_field_writer.sv
// Combinational masked byte write: replaces size_bytes(size) bytes of the header
// starting at byte offset with the low bytes of value. Bytes past the header
// end are simply not written; bounds policy lives in the caller.
module deparse_field_writer
  import menshen_deparse_pkg::*;
#(
  parameter int PKTS_HDR_LEN = 1024,
  parameter int VAL_IN_LEN   = 48
) (
  input  logic [PKTS_HDR_LEN-1:0] header_i,
  input  logic [6:0]              offset_i,
  input  logic [1:0]              size_i,
  input  logic [VAL_IN_LEN-1:0]   value_i,
  output logic [PKTS_HDR_LEN-1:0] header_o
);
  localparam int NBYTES = PKTS_HDR_LEN / 8;
  localparam int MAXB   = VAL_IN_LEN / 8;

  int nb;
  assign nb = size_bytes(size_i);

  // Per output byte: take value byte k when it lands on this byte, else pass through
  always_comb begin
    header_o = header_i;
    for (int b = 0; b < NBYTES; b++) begin
      for (int k = 0; k < MAXB; k++) begin
        if (k < nb && b == int'(offset_i) + k)
          header_o[b*8 +: 8] = value_i[k*8 +: 8];
      end
    end
  end
endmodule

// File: rtl/sub_deparser.sv
// sub_deparser: loads a packet header, applies a stream of write actions
// (later writes win), then presents the rebuilt header.
// Optional feature: define SUB_DEPARSER_STATS_EN to add the 16-bit saturating
// drop_cnt output counting out-of-bounds actions.
module sub_deparser
  import menshen_deparse_pkg::*;
#(
  parameter int PKTS_HDR_LEN    = 1024,
  parameter int DEPARSE_ACT_LEN = 16,
  parameter int VAL_IN_LEN      = 48
) (
  input  logic         clk,
  input  logic         rst,
  sub_deparser_if.slave bus
`ifdef SUB_DEPARSER_STATS_EN
  ,
  output logic [15:0]  drop_cnt
`endif
);
  logic [1:0]              state_q, state_d;
  logic [PKTS_HDR_LEN-1:0] hdr_q, hdr_d, hdr_wr;
  act_dec_t                dec;
  int                      nbytes;
  logic                    accept, oob, wr_en;

  // Sequence field and upper action bits carry no meaning here
  logic unused_act;
  assign unused_act = ^{bus.act[ACT_SEQ_MSB:ACT_SEQ_LSB], bus.act[DEPARSE_ACT_LEN-1:ACT_OFF_MSB+1]};

  assign dec.en   = bus.act[ACT_EN_BIT];
  assign dec.size = bus.act[ACT_SIZE_MSB:ACT_SIZE_LSB];
  assign dec.off  = bus.act[ACT_OFF_MSB:ACT_OFF_LSB];
  assign nbytes   = size_bytes(dec.size);

  assign accept = bus.act_valid && (state_q == ST_COLLECT);
  assign oob    = (int'(dec.off) * 8 + nbytes * 8) > PKTS_HDR_LEN;
  assign wr_en  = accept && dec.en && (dec.size != SIZE_NONE) && !oob;

  assign bus.hdr_in_ready  = (state_q == ST_IDLE);
  assign bus.act_ready     = (state_q == ST_COLLECT);
  assign bus.hdr_out_valid = (state_q == ST_EMIT);
  assign bus.hdr_out       = hdr_q;

  deparse_field_writer #(
    .PKTS_HDR_LEN(PKTS_HDR_LEN),
    .VAL_IN_LEN  (VAL_IN_LEN)
  ) u_writer (
    .header_i(hdr_q),
    .offset_i(dec.off),
    .size_i  (dec.size),
    .value_i (bus.act_val),
    .header_o(hdr_wr)
  );

  // Next-state and header update; inputs outside their state are ignored
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.hdr_in_valid) begin
          hdr_d   = bus.hdr_in;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (wr_en) hdr_d = hdr_wr;
        if (accept && bus.act_last) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.hdr_out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and header registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
    end
  end

`ifdef SUB_DEPARSER_STATS_EN
  logic [15:0] drop_q;
  assign drop_cnt = drop_q;

  // Count enabled actions rejected for running past the header end, saturating
  always_ff @(posedge clk) begin
    if (rst)
      drop_q <= '0;
    else if (accept && dec.en && (dec.size != SIZE_NONE) && oob && drop_q != 16'hFFFF)
      drop_q <= drop_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sub_deparser.sv
// Scoreboard bench for sub_deparser: stimulus updates a byte-level header model
// and queues the expected header plus its arrival cycle; a monitor compares.
module tb_sub_deparser;
  localparam int HL = 1024, AL = 16, VL = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_deparser_if #(.PKTS_HDR_LEN(HL), .DEPARSE_ACT_LEN(AL), .VAL_IN_LEN(VL)) bus ();
`ifdef SUB_DEPARSER_STATS_EN
  logic [15:0] drop_cnt;
`endif

  sub_deparser #(.PKTS_HDR_LEN(HL), .DEPARSE_ACT_LEN(AL), .VAL_IN_LEN(VL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SUB_DEPARSER_STATS_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int n_pass = 0, n_tot = 0;
  logic [HL-1:0] model;
  logic [HL-1:0] exp_q[$];
  int at_q[$];
  int neg_cnt = 0;
  int drops = 0;

  task automatic chk32(input string nm, input int unsigned got, input int unsigned exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_hdr(input string nm, input logic [HL-1:0] got, input logic [HL-1:0] exp);
    int bad;
    bad = -1;
    for (int b = HL/8-1; b >= 0; b--) if (got[b*8 +: 8] !== exp[b*8 +: 8]) bad = b;
    n_tot++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: byte %0d got %02h expected %02h", nm, bad, got[bad*8 +: 8], exp[bad*8 +: 8]);
  endtask

  function automatic logic [HL-1:0] rand_hdr();
    logic [HL-1:0] r;
    for (int i = 0; i < HL/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: first valid cycle checks data and latency; later valid cycles check hold
  logic in_emit = 1'b0;
  logic [HL-1:0] cur;
  always @(negedge clk) begin
    neg_cnt++;
    if (!rst && bus.hdr_out_valid) begin
      if (!in_emit) begin
        in_emit = 1'b1;
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_output: got hdr_out_valid=1 expected no packet");
          cur = bus.hdr_out;
        end else begin
          cur = exp_q.pop_front();
          chk_hdr("hdr_out", bus.hdr_out, cur);
          chk32("latency", neg_cnt, at_q.pop_front());
        end
      end else begin
        chk_hdr("hdr_out_hold", bus.hdr_out, cur);
        chk32("hdr_in_ready_in_emit", bus.hdr_in_ready, 0);
        chk32("act_ready_in_emit", bus.act_ready, 0);
      end
    end else in_emit = 1'b0;
  end

  task automatic clear_inputs();
    bus.hdr_in_valid = 0; bus.hdr_in = '0; bus.act_valid = 0; bus.act = '0;
    bus.act_val = '0; bus.act_last = 0; bus.hdr_out_ready = 0;
  endtask

  task automatic do_reset();
    #1 rst = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0; drops = 0;
    @(negedge clk);
    chk32("rst_hdr_in_ready", bus.hdr_in_ready, 1);
    chk32("rst_act_ready", bus.act_ready, 0);
    chk32("rst_hdr_out_valid", bus.hdr_out_valid, 0);
    chk_hdr("rst_hdr_reg", bus.hdr_out, '0);
`ifdef SUB_DEPARSER_STATS_EN
    chk32("rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk);
  endtask

  task automatic load_hdr(input logic [HL-1:0] h);
    int n;
    #1 bus.hdr_in_valid = 1; bus.hdr_in = h; bus.act_valid = 0; bus.hdr_out_ready = 0;
    @(negedge clk);
    n = 0;
    while (!bus.hdr_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin n_tot++; $display("FAIL load_timeout: got hdr_in_ready=0 expected 1"); end
    @(posedge clk);
    model = h;
  endtask

  task automatic send_act(input bit en, input logic [1:0] sz, input int off,
                          input logic [VL-1:0] val, input bit last);
    logic [AL-1:0] a;
    int n, nb;
    a = AL'($urandom);
    a[0] = en; a[5:4] = sz; a[12:6] = 7'(off);
    #1 bus.act_valid = 1; bus.act = a; bus.act_val = val; bus.act_last = last;
    bus.hdr_in_valid = 1'($urandom); bus.hdr_in = rand_hdr();
    @(negedge clk);
    n = 0;
    while (!bus.act_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin n_tot++; $display("FAIL act_timeout: got act_ready=0 expected 1"); end
    @(posedge clk);
    nb = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : (sz == 2'b11) ? 6 : 0;
    if (en && nb > 0) begin
      if (off + nb <= HL/8) for (int k = 0; k < nb; k++) model[(off+k)*8 +: 8] = val[k*8 +: 8];
      else if (drops < 65535) drops++;
    end
    if (last) begin exp_q.push_back(model); at_q.push_back(neg_cnt + 1); end
  endtask

  // Hold ready low for 'hold' valid cycles while poking ignored inputs, then accept
  task automatic drain(input int hold);
    int n;
    #1 bus.hdr_in_valid = 1; bus.hdr_in = rand_hdr(); bus.act_valid = 1;
    bus.act = 16'h0011; bus.act_val = 48'hFFFF_FFFF_FFFF; bus.act_last = 1; bus.hdr_out_ready = 0;
    @(negedge clk);
    n = 0;
    while (!bus.hdr_out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin n_tot++; $display("FAIL emit_timeout: got hdr_out_valid=0 expected 1"); end
    repeat (hold) @(negedge clk);
    bus.hdr_out_ready = 1;
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    chk32("idle_after_emit", bus.hdr_in_ready, 1);
    chk32("valid_drop_after_emit", bus.hdr_out_valid, 0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    do_reset();

    // Single 2B write into a zero header
    load_hdr('0);
    send_act(1, 2'b01, 10, 48'h0000_0000_BEEF, 1);
    drain(0);

    // Back-to-back writes with overlap, later wins
    load_hdr('0);
    send_act(1, 2'b10, 0, 48'h0000_1122_3344, 0);
    send_act(1, 2'b11, 20, 48'hA1A2_A3A4_A5A6, 0);
    send_act(1, 2'b01, 2, 48'h0000_0000_5566, 1);
    drain(0);

    // Out-of-bounds writes leave header unchanged
    load_hdr(rand_hdr());
    send_act(1, 2'b01, 127, 48'h1234_5678_9ABC, 0);
    send_act(1, 2'b11, 124, 48'h1234_5678_9ABC, 1);
    drain(0);
`ifdef SUB_DEPARSER_STATS_EN
    chk32("drop_cnt", drop_cnt, drops);
`endif

    // Backpressure in EMIT
    load_hdr(rand_hdr());
    send_act(1, 2'b10, 64, 48'($urandom), 1);
    drain(5);

    // Reset mid-collect abandons the packet
    load_hdr(rand_hdr());
    send_act(1, 2'b01, 3, 48'($urandom), 0);
    send_act(1, 2'b10, 40, 48'($urandom), 0);
    do_reset();
    load_hdr(rand_hdr());
    send_act(1, 2'b11, 100, {$urandom, 16'($urandom)}, 1);
    drain(1);

    // Action pulse in IDLE is ignored; disabled last action ends collection
    #1 bus.act_valid = 1; bus.act = 16'h0011; bus.act_val = 48'hDEAD; bus.act_last = 1;
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    chk32("idle_ignores_act", bus.hdr_in_ready, 1);
    chk32("idle_act_ready", bus.act_ready, 0);
    @(posedge clk);
    load_hdr(rand_hdr());
    send_act(0, 2'b01, 5, 48'hCAFE, 1);
    drain(0);

    // Randomized packets
    for (int p = 0; p < 25; p++) begin
      int na;
      load_hdr(rand_hdr());
      na = $urandom_range(1, 6);
      for (int i = 0; i < na; i++)
        send_act(($urandom % 8) != 0, 2'($urandom), $urandom_range(0, 127),
                 {$urandom, 16'($urandom)}, i == na - 1);
      drain($urandom_range(0, 3));
    end
`ifdef SUB_DEPARSER_STATS_EN
    chk32("drop_cnt_random", drop_cnt, drops);
`endif

    repeat (5) @(posedge clk);
    chk32("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sub_deparser.md
SUB_DEPARSER -- requirements
Module: sub_deparser

Interface
REQ-001 SHALL have parameter PKTS_HDR_LEN, default 1024, header width in bits.
REQ-002 SHALL have parameter DEPARSE_ACT_LEN, default 16, action word width.
REQ-003 SHALL have parameter VAL_IN_LEN, default 48, container value width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports hdr_in_valid input 1, hdr_in input PKTS_HDR_LEN, hdr_in_ready output 1: header load handshake.
REQ-007 SHALL have ports act_valid input 1, act input DEPARSE_ACT_LEN, act_val input VAL_IN_LEN, act_last input 1, act_ready output 1: write-action stream.
REQ-008 SHALL have ports hdr_out_valid output 1, hdr_out output PKTS_HDR_LEN, hdr_out_ready input 1: rebuilt header.

Function
REQ-009 SHALL implement FSM IDLE, COLLECT, EMIT.
REQ-010 SHALL drive hdr_in_ready=1 only in IDLE, act_ready=1 only in COLLECT, and hdr_out_valid=1 only in EMIT.
REQ-011 SHALL, in IDLE on hdr_in_valid, latch hdr_in into the internal header register and enter COLLECT next cycle.
REQ-012 SHALL decode each accepted action: act[0] enable; act[3:1] sequence (ignored); act[5:4] size (01=2B, 10=4B, 11=6B, 00=none); act[12:6] byte offset.
REQ-013 SHALL, on an enabled, in-bounds action, overwrite header bits [offset*8 +: N*8] with act_val[N*8-1:0] in the acceptance cycle, where N is the size in bytes.
REQ-014 SHALL treat an action as a no-op, without writing, when act[0]=0, size=00, or offset*8+N*8 > PKTS_HDR_LEN.
REQ-015 SHALL accept one action per cycle with no bubbles; overlapping writes SHALL resolve with the later action winning.
REQ-016 SHALL, on an accepted action with act_last=1, apply that action and then enter EMIT next cycle; act_last on a no-op action SHALL still end collection.
REQ-017 SHALL, in EMIT, hold hdr_out stable at the final header value until hdr_out_ready=1, then return to IDLE.
REQ-018 SHALL give a latency of exactly one cycle from the last action's acceptance to hdr_out_valid=1.
REQ-019 SHALL ignore hdr_in_valid outside IDLE and act_valid outside COLLECT, leaving all state unaffected.
REQ-020 SHALL, when a header handshake completes and the FSM returns to IDLE in the same cycle, require a new header load before further actions are accepted.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, enter IDLE and clear the header register, hdr_out_valid, act_ready, and (when present) drop_cnt to 0; hdr_in_ready SHALL be 1 from the first cycle after reset.
REQ-022 SHALL, on reset mid-COLLECT or mid-EMIT, abandon the packet with no partial output.

Configuration
REQ-023 SHALL, with SUB_DEPARSER_STATS_EN defined, add output port drop_cnt (16 bits), incremented once per action rejected as out-of-bounds and saturating at 16'hFFFF.
REQ-024 SHALL, without SUB_DEPARSER_STATS_EN, omit the drop_cnt port and its logic, leaving all other behaviour identical.

Structure
REQ-025 SHALL take action field positions, size encodings (2'b01/2'b10/2'b11), and the FSM state encoding from shared package menshen_deparse_pkg, which the parser side also uses.
REQ-026 SHALL place the combinational masked byte-write in sub-module deparse_field_writer, with inputs header, offset, size, and value, and output the updated header.

Verification
REQ-027 SHALL verify: header all 0x00; action size=01, offset=10, val=0xBEEF, act_last=1 -> hdr_out[95:80]=0xBEEF, all other bits 0, hdr_out_valid one cycle after the action.
REQ-028 SHALL verify: three back-to-back actions (4B@0=0x11223344, 6B@20=0xA1A2A3A4A5A6, 2B@2=0x5566, last) -> all written; bits [31:16]=0x5566 (later wins).
REQ-029 SHALL verify: 2B@127 and 6B@124 -> header unchanged; with SUB_DEPARSER_STATS_EN, drop_cnt=2.
REQ-030 SHALL verify: hdr_out_ready held low 5 cycles in EMIT -> hdr_out stable, hdr_in_ready=0, act_ready=0; on ready=1, back to IDLE the next cycle.
REQ-031 SHALL verify: rst asserted after 2 of 4 actions -> no hdr_out_valid; a new header plus a single last action then produces correct output.
REQ-032 SHALL verify: act_valid pulsed in IDLE and act[0]=0 with act_last=1 in COLLECT -> IDLE pulse ignored; EMIT outputs the unmodified header.
